// File: rtl/ucsbece154_icache.sv
// Two-way set-associative, read-only instruction cache in front of a burst instruction memory.
// Hits answer in the same cycle; a miss issues one block-aligned burst and refills the victim way.
module ucsbece154_icache #(
    parameter int NUM_SETS    = 8,
    parameter int NUM_WAYS    = 2,
    parameter int BLOCK_WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ReadEnable,
    input  logic [31:0] ReadAddress,
    output logic [31:0] Instruction,
    output logic        Ready,
    output logic        Busy,
    output logic        MemReadRequest,
    output logic [31:0] MemReadAddress,
    input  logic [31:0] MemDataIn,
    input  logic        MemDataReady
);
    localparam int OFF_W = $clog2(BLOCK_WORDS);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = 30 - OFF_W - IDX_W;
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t                            r_state;
    logic [OFF_W-1:0]                  r_wcnt;
    logic [OFF_W-1:0]                  r_off;
    logic [IDX_W-1:0]                  r_idx;
    logic [TAG_W-1:0]                  r_tag;
    logic                              r_way;
    logic [NUM_SETS-1:0][NUM_WAYS-1:0] r_valid;
    logic [NUM_SETS-1:0]               r_lru;
    logic [TAG_W-1:0]                  r_tags [NUM_SETS][NUM_WAYS];
    logic [31:0]                       r_data [NUM_SETS][NUM_WAYS][BLOCK_WORDS];

    logic [OFF_W-1:0] w_off;
    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic             w_hit0;
    logic             w_hit1;
    logic             w_lookup;
    logic             w_hit;
    logic             w_miss;
    logic             w_victim;
    logic             w_fill;
    logic             w_last;
    logic             w_unused;

    assign w_off    = ReadAddress[2 +: OFF_W];
    assign w_idx    = ReadAddress[2 + OFF_W +: IDX_W];
    assign w_tag    = ReadAddress[31 -: TAG_W];
    assign w_hit0   = r_valid[w_idx][0] && (r_tags[w_idx][0] == w_tag);
    assign w_hit1   = r_valid[w_idx][1] && (r_tags[w_idx][1] == w_tag);
    assign w_lookup = (r_state == IDLE) && ReadEnable;
    assign w_hit    = w_lookup && (w_hit0 || w_hit1);
    assign w_miss   = w_lookup && !(w_hit0 || w_hit1);
    // Fill an empty way first (way0 preferred); only evict by LRU when the set is full.
    assign w_victim = !r_valid[w_idx][0] ? 1'b0 :
                      !r_valid[w_idx][1] ? 1'b1 : r_lru[w_idx];
    assign w_fill   = (r_state == WAIT) && MemDataReady;
    assign w_last   = w_fill && (r_wcnt == LAST_WORD);
    assign w_unused = ^ReadAddress[1:0];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_wcnt  <= '0;
            r_off   <= '0;
            r_idx   <= '0;
            r_tag   <= '0;
            r_way   <= 1'b0;
            r_valid <= '0;
            r_lru   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hit) begin
                        r_lru[w_idx] <= !w_hit1;
                    end else if (w_miss) begin
                        r_tag   <= w_tag;
                        r_idx   <= w_idx;
                        r_off   <= w_off;
                        r_way   <= w_victim;
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    r_wcnt  <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (w_fill) begin
                        r_wcnt <= r_wcnt + 1'b1;
                    end
                    if (w_last) begin
                        r_valid[r_idx][r_way] <= 1'b1;
                        r_lru[r_idx]          <= !r_way;
                        r_state               <= DONE;
                    end
                end
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // NOTE: line data and tags have no reset; the valid bits alone decide whether a way can hit.
    always_ff @(posedge clk) begin
        if (!reset && w_fill) begin
            r_data[r_idx][r_way][r_wcnt] <= MemDataIn;
            if (w_last) begin
                r_tags[r_idx][r_way] <= r_tag;
            end
        end
    end

    // NOTE: every output gets a default first so this block can never infer a latch.
    always_comb begin
        Ready          = 1'b0;
        Instruction    = '0;
        Busy           = w_miss || (r_state == REQ) || (r_state == WAIT);
        MemReadRequest = (r_state == REQ);
        MemReadAddress = '0;
        if (w_hit) begin
            Ready       = 1'b1;
            Instruction = r_data[w_idx][w_hit1][w_off];
        end else if (r_state == DONE) begin
            Ready       = 1'b1;
            Instruction = r_data[r_idx][r_way][r_off];
        end
        if ((r_state == REQ) || (r_state == WAIT)) begin
            MemReadAddress = {r_tag, r_idx, {OFF_W{1'b0}}, 2'b00};
        end
    end

endmodule

// File: tb/tb_ucsbece154_icache.sv
// Directed bench for ucsbece154_icache with a fixed-latency burst memory model.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_ucsbece154_icache;
    localparam int T0_DELAY    = 40;
    localparam int BLOCK_WORDS = 4;
    localparam int MISS_LAT    = T0_DELAY + BLOCK_WORDS + 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        ReadEnable;
    logic [31:0] ReadAddress;
    logic [31:0] Instruction;
    logic        Ready;
    logic        Busy;
    logic        MemReadRequest;
    logic [31:0] MemReadAddress;
    logic [31:0] MemDataIn;
    logic        MemDataReady;

    int   n_checks  = 0;
    int   n_fail    = 0;
    int   req_count = 0;
    logic mem_busy  = 1'b0;

    ucsbece154_icache #(.NUM_SETS(8), .NUM_WAYS(2), .BLOCK_WORDS(BLOCK_WORDS)) dut (
        .clk            (clk),
        .reset          (reset),
        .ReadEnable     (ReadEnable),
        .ReadAddress    (ReadAddress),
        .Instruction    (Instruction),
        .Ready          (Ready),
        .Busy           (Busy),
        .MemReadRequest (MemReadRequest),
        .MemReadAddress (MemReadAddress),
        .MemDataIn      (MemDataIn),
        .MemDataReady   (MemDataReady)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h0F0F_3C3C;
    endfunction

    // Burst memory: first word T0_DELAY+1 cycles after the request cycle, then one word per cycle.
    initial begin
        logic [31:0] base;
        MemDataReady = 1'b0;
        MemDataIn    = '0;
        forever begin
            @(negedge clk);
            if (MemReadRequest === 1'b1) begin
                req_count++;
                mem_busy = 1'b1;
                base     = MemReadAddress;
                repeat (T0_DELAY + 1) @(negedge clk);
                for (int i = 0; i < BLOCK_WORDS; i++) begin
                    MemDataReady = 1'b1;
                    MemDataIn    = mem_word(base + 32'(4 * i));
                    @(negedge clk);
                end
                MemDataReady = 1'b0;
                MemDataIn    = '0;
                mem_busy     = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // Starts at a falling edge; returns the cycles until Ready and the word delivered.
    task automatic fetch_wait(input logic [31:0] addr, input int budget,
                              output int lat, output logic [31:0] instr);
        ReadEnable  = 1'b1;
        ReadAddress = addr;
        #1;
        lat = 0;
        while (Ready !== 1'b1 && lat < budget) begin
            @(negedge clk);
            #1;
            lat++;
        end
        instr = Instruction;
        @(negedge clk);
        ReadEnable = 1'b0;
    endtask

    task automatic test_reset();
        logic [98:0] outs;
        reset       = 1'b1;
        ReadEnable  = 1'b0;
        ReadAddress = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        outs = {Ready, Busy, MemReadRequest, MemReadAddress, Instruction, 32'd0};
        n_checks++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            outs = {Ready, Busy, MemReadRequest, MemReadAddress, Instruction, 32'd0};
            n_checks++;
            if (outs !== '0) begin
                n_fail++;
                $display("FAIL idle_outputs cycle %0d: got %h expected 0", i, outs);
            end
        end
        n_checks++;
        if (req_count !== 0) begin
            n_fail++;
            $display("FAIL idle_no_request: got %0d requests expected 0", req_count);
        end
        @(negedge clk);
    endtask

    task automatic test_cold_miss();
        int          c        = 0;
        int          req_cyc  = -1;
        logic [31:0] req_addr = '0;
        logic        busy_ok  = 1'b1;
        ReadEnable  = 1'b1;
        ReadAddress = 32'h0001_0008;
        #1;
        while (Ready !== 1'b1 && c < 100) begin
            if (MemReadRequest === 1'b1) begin
                req_cyc  = c;
                req_addr = MemReadAddress;
            end
            if (Busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            #1;
            c++;
        end
        n_checks++;
        if (req_cyc !== 1) begin
            n_fail++;
            $display("FAIL cold_req_cycle: got %0d expected 1", req_cyc);
        end
        n_checks++;
        if (req_addr !== 32'h0001_0000) begin
            n_fail++;
            $display("FAIL cold_req_addr: got %h expected 00010000", req_addr);
        end
        n_checks++;
        if (busy_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL cold_busy: Busy dropped before Ready");
        end
        n_checks++;
        if (c !== MISS_LAT) begin
            n_fail++;
            $display("FAIL cold_latency: got %0d expected %0d", c, MISS_LAT);
        end
        n_checks++;
        if (Instruction !== mem_word(32'h0001_0008)) begin
            n_fail++;
            $display("FAIL cold_instr: got %h expected %h", Instruction, mem_word(32'h0001_0008));
        end
        n_checks++;
        if (Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL cold_done_busy: got %b expected 0", Busy);
        end
        @(negedge clk);
        ReadEnable = 1'b0;
    endtask

    task automatic test_hits();
        int base = req_count;
        for (int i = 0; i < 4; i++) begin
            ReadEnable  = 1'b1;
            ReadAddress = 32'h0001_0000 + 32'(4 * i);
            #1;
            n_checks++;
            if (Ready !== 1'b1 || Busy !== 1'b0 || Instruction !== mem_word(ReadAddress)) begin
                n_fail++;
                $display("FAIL hit_word%0d: got ready=%b busy=%b instr=%h expected ready=1 busy=0 instr=%h",
                         i, Ready, Busy, Instruction, mem_word(ReadAddress));
            end
            @(negedge clk);
        end
        ReadEnable = 1'b0;
        @(negedge clk);
        n_checks++;
        if (req_count !== base) begin
            n_fail++;
            $display("FAIL hit_no_request: got %0d requests expected %0d", req_count, base);
        end
    endtask

    task automatic test_lru();
        int          lat;
        logic [31:0] instr;
        int          base = req_count;
        fetch_wait(32'h0001_0080, 100, lat, instr);
        n_checks++;
        if (lat !== MISS_LAT || instr !== mem_word(32'h0001_0080)) begin
            n_fail++;
            $display("FAIL lru_fill_0080: got lat=%0d instr=%h expected lat=%0d instr=%h",
                     lat, instr, MISS_LAT, mem_word(32'h0001_0080));
        end
        fetch_wait(32'h0001_0000, 100, lat, instr);
        n_checks++;
        if (lat !== 0 || instr !== mem_word(32'h0001_0000)) begin
            n_fail++;
            $display("FAIL lru_hit_0000: got lat=%0d instr=%h expected lat=0 instr=%h",
                     lat, instr, mem_word(32'h0001_0000));
        end
        fetch_wait(32'h0001_0100, 100, lat, instr);
        n_checks++;
        if (lat !== MISS_LAT || instr !== mem_word(32'h0001_0100)) begin
            n_fail++;
            $display("FAIL lru_fill_0100: got lat=%0d instr=%h expected lat=%0d instr=%h",
                     lat, instr, MISS_LAT, mem_word(32'h0001_0100));
        end
        fetch_wait(32'h0001_0004, 100, lat, instr);
        n_checks++;
        if (lat !== 0 || instr !== mem_word(32'h0001_0004)) begin
            n_fail++;
            $display("FAIL lru_kept_0000: got lat=%0d instr=%h expected lat=0 instr=%h",
                     lat, instr, mem_word(32'h0001_0004));
        end
        fetch_wait(32'h0001_0084, 100, lat, instr);
        n_checks++;
        if (lat !== MISS_LAT || instr !== mem_word(32'h0001_0084)) begin
            n_fail++;
            $display("FAIL lru_evicted_0080: got lat=%0d instr=%h expected lat=%0d instr=%h",
                     lat, instr, MISS_LAT, mem_word(32'h0001_0084));
        end
        n_checks++;
        if (req_count !== base + 3) begin
            n_fail++;
            $display("FAIL lru_requests: got %0d expected %0d", req_count, base + 3);
        end
    endtask

    task automatic test_stall_isolation();
        int          c        = 0;
        int          base     = req_count;
        logic [31:0] req_addr = '0;
        logic        busy_mid = 1'b0;
        ReadEnable  = 1'b1;
        ReadAddress = 32'h0001_001C;
        #1;
        while (Ready !== 1'b1 && c < 100) begin
            @(negedge clk);
            c++;
            if (c == 1) ReadAddress = 32'h0001_0040;
            if (c == 5) ReadEnable = 1'b0;
            #1;
            if (MemReadRequest === 1'b1) req_addr = MemReadAddress;
            if (c == 10) busy_mid = Busy;
        end
        n_checks++;
        if (c !== MISS_LAT || Instruction !== mem_word(32'h0001_001C)) begin
            n_fail++;
            $display("FAIL stall_done: got lat=%0d instr=%h expected lat=%0d instr=%h",
                     c, Instruction, MISS_LAT, mem_word(32'h0001_001C));
        end
        n_checks++;
        if (req_addr !== 32'h0001_0010 || busy_mid !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_request: got addr=%h busy=%b expected addr=00010010 busy=1",
                     req_addr, busy_mid);
        end
        repeat (4) @(negedge clk);
        #1;
        n_checks++;
        if (req_count !== base + 1 || Ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_single_request: got requests=%0d ready=%b expected requests=%0d ready=0",
                     req_count, Ready, base + 1);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_wait();
        int          c     = 0;
        int          words = 0;
        int          lat;
        int          base;
        logic [31:0] instr;
        logic [98:0] outs;
        ReadEnable  = 1'b1;
        ReadAddress = 32'h0001_0020;
        #1;
        while (words < 2 && c < 100) begin
            @(negedge clk);
            #1;
            c++;
            if (MemDataReady === 1'b1) words++;
        end
        n_checks++;
        if (words !== 2) begin
            n_fail++;
            $display("FAIL rst_wait_words: got %0d words expected 2", words);
        end
        @(negedge clk);
        reset      = 1'b1;
        ReadEnable = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        outs = {Ready, Busy, MemReadRequest, MemReadAddress, Instruction, 32'd0};
        n_checks++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got %h expected 0", outs);
        end
        c = 0;
        while (mem_busy === 1'b1 && c < 100) begin
            @(negedge clk);
            c++;
        end
        n_checks++;
        if (mem_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mem_idle: memory still busy after %0d cycles", c);
        end
        @(negedge clk);
        base = req_count;
        fetch_wait(32'h0001_0020, 100, lat, instr);
        n_checks++;
        if (lat !== MISS_LAT || instr !== mem_word(32'h0001_0020)) begin
            n_fail++;
            $display("FAIL rst_refetch: got lat=%0d instr=%h expected lat=%0d instr=%h",
                     lat, instr, MISS_LAT, mem_word(32'h0001_0020));
        end
        fetch_wait(32'h0001_0000, 100, lat, instr);
        n_checks++;
        if (lat !== MISS_LAT || instr !== mem_word(32'h0001_0000)) begin
            n_fail++;
            $display("FAIL rst_cleared_line: got lat=%0d instr=%h expected lat=%0d instr=%h",
                     lat, instr, MISS_LAT, mem_word(32'h0001_0000));
        end
        n_checks++;
        if (req_count !== base + 2) begin
            n_fail++;
            $display("FAIL rst_requests: got %0d expected %0d", req_count, base + 2);
        end
    endtask

    initial begin
        reset       = 1'b1;
        ReadEnable  = 1'b0;
        ReadAddress = '0;
        test_reset();
        test_cold_miss();
        test_hits();
        test_lru();
        test_stall_isolation();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
